// File: rtl/imm_pkg.sv
// Shared opcodes, immediate-class encodings and skid-buffer states for the
// immediate generator on the decode path.
package imm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_SH   = 3'd6,
        IMM_Z    = 3'd7
    } imm_type_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and classification for one RISC-V
// instruction word, extended to XLEN bits.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter bit HALF_BR = 1'b0
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    logic        w_sh;
    logic [31:0] w_i, w_s, w_b, w_j, w_u;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        sext       = {XLEN{v[31]}};
        sext[31:0] = v;
    endfunction

    assign w_sh = (inst[14:12] == 3'b001) || (inst[14:12] == 3'b101);
    assign w_i  = {{20{inst[31]}}, inst[31:20]};
    assign w_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign w_u  = {inst[31:12], 12'h000};
    // Half-offset form drops the always-zero bit 0, i.e. offset >>> 1.
    assign w_b  = HALF_BR ? {{20{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8]}
                          : {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_j  = HALF_BR ? {{12{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21]}
                          : {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        imm      = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (inst[6:0])
            OP_LOAD, OP_JALR: begin
                imm_type = IMM_I;
                imm      = sext(w_i);
            end
            OP_IMM: begin
                if (!w_sh) begin
                    imm_type = IMM_I;
                    imm      = sext(w_i);
                end else if (XLEN == 32 && inst[25]) begin
                    // shamt >= 32 has no meaning on a 32-bit datapath
                    illegal = 1'b1;
                end else begin
                    imm_type = IMM_SH;
                    imm[5:0] = inst[25:20];
                end
            end
            OP_IMM32: begin
                if (XLEN == 32) begin
                    illegal = 1'b1;
                end else if (!w_sh) begin
                    imm_type = IMM_I;
                    imm      = sext(w_i);
                end else begin
                    imm_type = IMM_SH;
                    imm[4:0] = inst[24:20];
                end
            end
            OP_STORE: begin
                imm_type = IMM_S;
                imm      = sext(w_s);
            end
            OP_BRANCH: begin
                imm_type = IMM_B;
                imm      = sext(w_b);
            end
            OP_JAL: begin
                imm_type = IMM_J;
                imm      = sext(w_j);
            end
            OP_LUI, OP_AUIPC: begin
                imm_type = IMM_U;
                imm      = sext(w_u);
            end
            OP_SYSTEM: begin
                imm_type  = IMM_Z;
                imm[11:0] = inst[31:20];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator stage: decode feeding a 2-entry skid buffer with flush
// and a saturating count of accepted unrecognised opcodes.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter bit HALF_BR = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] unk_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_e       ty;
        logic [XLEN-1:0] pc;
        logic            ill;
    } ent_t;

    buf_state_e       r_state, w_nxt;
    ent_t             r_out, r_skid, w_new;
    logic [XLEN-1:0]  w_imm;
    imm_type_e        w_ty;
    logic             w_ill, w_acc, w_drain;
    logic             w_load_out, w_load_skid, w_skid2out;
    logic [CNT_W-1:0] r_cnt;

    imm_decode #(.XLEN(XLEN), .HALF_BR(HALF_BR)) u_dec (
        .inst     (in_inst),
        .imm      (w_imm),
        .imm_type (w_ty),
        .illegal  (w_ill)
    );

    assign w_new = '{imm: w_imm, ty: w_ty, pc: in_pc, ill: w_ill};

    // Both handshake flags come straight off the state register.
    assign in_ready  = (r_state != BUF_FULL);
    assign out_valid = (r_state != BUF_EMPTY);
    assign w_acc     = in_valid & in_ready & ~flush;
    assign w_drain   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BUF_EMPTY;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt       = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_skid2out  = 1'b0;
        if (flush) begin
            w_nxt = BUF_EMPTY;
        end else begin
            case (r_state)
                BUF_EMPTY: if (w_acc) begin
                    w_nxt      = BUF_ONE;
                    w_load_out = 1'b1;
                end
                BUF_ONE: begin
                    if (w_acc && w_drain) begin
                        w_load_out = 1'b1;
                    end else if (w_acc) begin
                        w_nxt       = BUF_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_drain) begin
                        w_nxt = BUF_EMPTY;
                    end
                end
                BUF_FULL: if (w_drain) begin
                    w_nxt      = BUF_ONE;
                    w_skid2out = 1'b1;
                end
                default: w_nxt = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_skid2out)      r_out <= r_skid;
            else if (w_load_out) r_out <= w_new;
            if (w_load_skid)     r_skid <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     r_cnt <= '0;
        else if (w_acc && w_ill && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end

    assign out_imm     = r_out.imm;
    assign out_type    = r_out.ty;
    assign out_pc      = r_out.pc;
    assign out_illegal = r_out.ill;
    assign unk_cnt     = r_cnt;

endmodule
